// File: rtl/mem_access_pkg.sv
// Shared definitions for the unified memory-port access controller.
// Contents: controller state encoding, dm_size encodings, default
// byte-address width of the memory port.
package mem_access_pkg;

  localparam int DEF_ADDR_W = 12;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_DATA  = 1'b1
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

endpackage

// File: rtl/mem_align_check.sv
// Combinational alignment check for a load/store request.
// Ports:
//   size    - access size (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL)
//   addr_lo - two least significant byte-address bits
//   legal   - 1 when the request may be issued to memory
module mem_align_check
  import mem_access_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    case (size)
      SZ_BYTE: legal = 1'b1;
      SZ_HALF: legal = (addr_lo[0] == 1'b0);
      SZ_WORD: legal = (addr_lo == 2'b00);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-port memory access controller: arbitrates instruction fetch and
// load/store traffic onto one byte-addressable memory port.
// Ports:
//   clk, rst (async, active-low)
//   IF side : if_req, if_addr -> if_instr, if_valid, if_stall
//   MEM side: dm_req, dm_we, dm_size, dm_unsigned, dm_addr, dm_wdata
//             -> dm_ready, dm_rdata, dm_done, dm_err
//   stall_cnt: saturating count of cycles in which IF is stalled
//   Memory  : MemRead, MemWrite, Byte, HalfWord, ZeroExtention, addr,
//             data_in (combinational) and mem_rdata (combinational return)
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_instr,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic              dm_unsigned,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_ready,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  output logic              dm_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Byte,
  output logic              HalfWord,
  output logic              ZeroExtention,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       data_in,
  input  logic [31:0]       mem_rdata
);

  state_t              state, state_nxt;
  logic                dm_legal;
  logic                accept;

  logic                lat_we_p1;
  logic [1:0]          lat_size_p1;
  logic                lat_uns_p1;
  logic [ADDR_W-1:0]   lat_addr_p1;
  logic [31:0]         lat_wdata_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  mem_align_check u_align (
    .size    (dm_size),
    .addr_lo (dm_addr[1:0]),
    .legal   (dm_legal)
  );

  // Fetch has priority in S_FETCH; an accepted data access takes the port
  // for exactly one cycle, which guarantees fetch progress between accesses.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      S_FETCH: begin
        if (dm_req && dm_legal) begin
          accept    = 1'b1;
          state_nxt = S_DATA;
        end
      end
      S_DATA:  state_nxt = S_FETCH;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign dm_ready = (state == S_FETCH);
  assign if_stall = (state == S_DATA);

  // Memory port controls, combinational from state and the latched request.
  // MemWrite is also gated by rst so a store in flight never commits once
  // reset asserts, independent of how the state flop settles.
  always_comb begin
    addr          = if_addr;
    data_in       = lat_wdata_p1;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    Byte          = 1'b0;
    HalfWord      = 1'b0;
    ZeroExtention = 1'b0;
    if (state == S_DATA) begin
      addr          = lat_addr_p1;
      Byte          = (lat_size_p1 == SZ_BYTE);
      HalfWord      = (lat_size_p1 == SZ_HALF);
      ZeroExtention = lat_uns_p1;
      MemRead       = ~lat_we_p1;
      MemWrite      = lat_we_p1 & rst;
    end else if (if_req) begin
      MemRead = 1'b1;
    end
  end

  // p0 -> p1: request acceptance / fetch capture; p1 -> p2: data completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_FETCH;
      if_instr     <= '0;
      if_valid     <= 1'b0;
      dm_rdata     <= '0;
      dm_done      <= 1'b0;
      dm_err       <= 1'b0;
      stall_cnt    <= '0;
      lat_we_p1    <= 1'b0;
      lat_size_p1  <= SZ_BYTE;
      lat_uns_p1   <= 1'b0;
      lat_addr_p1  <= '0;
      lat_wdata_p1 <= '0;
    end else begin
      state    <= state_nxt;
      if_valid <= (state == S_FETCH) && if_req;
      dm_err   <= (state == S_FETCH) && dm_req && !dm_legal;
      dm_done  <= (state == S_DATA);
      if ((state == S_FETCH) && if_req) if_instr <= mem_rdata;
      if ((state == S_DATA) && !lat_we_p1) dm_rdata <= mem_rdata;
      if (state == S_DATA) stall_cnt <= sat_inc(stall_cnt);
      if (accept) begin
        lat_we_p1    <= dm_we;
        lat_size_p1  <= dm_size;
        lat_uns_p1   <= dm_unsigned;
        lat_addr_p1  <= dm_addr;
        lat_wdata_p1 <= dm_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed sequences, a vector
// table of data requests, and a randomized run against a transaction-level
// reference model with its own shadow memory.
module tb_mem_access_ctrl;

  localparam int AW = 12;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [31:0]   if_instr;
  logic          if_valid, if_stall;
  logic          dm_req, dm_we, dm_unsigned;
  logic [1:0]    dm_size;
  logic [AW-1:0] dm_addr;
  logic [31:0]   dm_wdata;
  logic          dm_ready, dm_done, dm_err;
  logic [31:0]   dm_rdata;
  logic [CW-1:0] stall_cnt;
  logic          MemRead, MemWrite, Byte, HalfWord, ZeroExtention;
  logic [AW-1:0] addr;
  logic [31:0]   data_in, mem_rdata;

  logic [7:0]    mem     [0:4095];
  logic [7:0]    ref_mem [0:4095];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_instr(if_instr),
    .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size),
    .dm_unsigned(dm_unsigned), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .dm_err(dm_err), .stall_cnt(stall_cnt),
    .MemRead(MemRead), .MemWrite(MemWrite), .Byte(Byte),
    .HalfWord(HalfWord), .ZeroExtention(ZeroExtention),
    .addr(addr), .data_in(data_in), .mem_rdata(mem_rdata)
  );

  // Memory macro: combinational read with size/extension handling.
  always_comb begin
    if (Byte)
      mem_rdata = ZeroExtention ? {24'h0, mem[addr]} : {{24{mem[addr][7]}}, mem[addr]};
    else if (HalfWord)
      mem_rdata = ZeroExtention ? {16'h0, mem[addr + 12'd1], mem[addr]}
                                : {{16{mem[addr + 12'd1][7]}}, mem[addr + 12'd1], mem[addr]};
    else
      mem_rdata = {mem[addr + 12'd3], mem[addr + 12'd2], mem[addr + 12'd1], mem[addr]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_dm(input logic req, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [AW-1:0] a, input logic [31:0] wd);
    dm_req = req; dm_we = we; dm_size = sz; dm_unsigned = uns; dm_addr = a; dm_wdata = wd;
  endtask

  // Reference model state (transaction level)
  logic          m_pend;
  logic          p_we, p_uns;
  logic [1:0]    p_sz;
  logic [AW-1:0] p_a;
  logic [31:0]   p_wd;
  logic [31:0]   m_rdata, m_instr;
  logic [CW-1:0] m_stall;
  logic          e_valid, e_done, e_err;

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic uns, input logic [AW-1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    b = ref_mem[a];
    h = {ref_mem[a + 12'd1], ref_mem[a]};
    if (sz == 2'd0) return uns ? 32'(b) : 32'($signed(b));
    if (sz == 2'd1) return uns ? 32'(h) : 32'($signed(h));
    return {ref_mem[a + 12'd3], ref_mem[a + 12'd2], h};
  endfunction

  task automatic model_step();
    logic legal;
    e_valid = 1'b0; e_done = 1'b0; e_err = 1'b0;
    if (m_pend) begin
      if (p_we) begin
        ref_mem[p_a] = p_wd[7:0];
        if (p_sz != 2'd0) ref_mem[p_a + 12'd1] = p_wd[15:8];
        if (p_sz == 2'd2) begin
          ref_mem[p_a + 12'd2] = p_wd[23:16];
          ref_mem[p_a + 12'd3] = p_wd[31:24];
        end
      end else begin
        m_rdata = ref_load(p_sz, p_uns, p_a);
      end
      e_done = 1'b1;
      if (m_stall != {CW{1'b1}}) m_stall = m_stall + 1;
      m_pend = 1'b0;
    end else begin
      if (if_req) begin
        e_valid = 1'b1;
        m_instr = ref_load(2'd2, 1'b0, if_addr);
      end
      if (dm_req) begin
        legal = (dm_size == 2'd0) || (dm_size == 2'd1 && dm_addr % 2 == 0) ||
                (dm_size == 2'd2 && dm_addr % 4 == 0);
        if (legal) begin
          m_pend = 1'b1;
          p_we = dm_we; p_sz = dm_size; p_uns = dm_unsigned; p_a = dm_addr; p_wd = dm_wdata;
        end else begin
          e_err = 1'b1;
        end
      end
    end
  endtask

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] a;
    logic [31:0]   wd;
    logic          err;
    logic [31:0]   rd;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h000] = 8'h13;
    {mem[12'h007], mem[12'h006], mem[12'h005], mem[12'h004]} = 32'h12345678;
    mem[12'h008] = 8'hAA;
    mem[1000] = 8'd17;
    mem[1004] = 8'd9;

    // Memory write port: commits at the clock edge when MemWrite is high.
    fork
      forever begin
        @(posedge clk);
        if (MemWrite) begin
          mem[addr] <= data_in[7:0];
          if (!Byte) mem[addr + 12'd1] <= data_in[15:8];
          if (!Byte && !HalfWord) begin
            mem[addr + 12'd2] <= data_in[23:16];
            mem[addr + 12'd3] <= data_in[31:24];
          end
        end
      end
    join_none

    // {we, size, uns, addr, wdata, expect_err, expected dm_rdata after}
    vecs[0] = '{1'b1, 2'b00, 1'b0, 12'h3E9, 32'hFFFFFF80, 1'b0, 32'd17};
    vecs[1] = '{1'b0, 2'b00, 1'b0, 12'h3E9, 32'h0,        1'b0, 32'hFFFFFF80};
    vecs[2] = '{1'b0, 2'b00, 1'b1, 12'h3E9, 32'h0,        1'b0, 32'h00000080};
    vecs[3] = '{1'b1, 2'b01, 1'b0, 12'h001, 32'h0000AAAA, 1'b1, 32'h00000080};
    vecs[4] = '{1'b1, 2'b10, 1'b0, 12'h002, 32'h55555555, 1'b1, 32'h00000080};
    vecs[5] = '{1'b0, 2'b11, 1'b0, 12'h000, 32'h0,        1'b1, 32'h00000080};
    vecs[6] = '{1'b0, 2'b10, 1'b0, 12'h000, 32'h0,        1'b0, 32'h00000013};
    vecs[7] = '{1'b0, 2'b10, 1'b0, 12'h3E8, 32'h0,        1'b0, 32'h00008011};
    vecs[8] = '{1'b1, 2'b01, 1'b0, 12'h3EA, 32'h0000BEEF, 1'b0, 32'h00008011};
    vecs[9] = '{1'b0, 2'b01, 1'b0, 12'h3EA, 32'h0,        1'b0, 32'hFFFFBEEF};

    // Reset state
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    drive_dm(1'b0, 1'b0, 2'b00, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rst_pulses", {if_valid, dm_done, dm_err}, 3'b000);
    chk("rst_ready_stall", {dm_ready, if_stall}, 2'b10);
    chk("rst_memwrite", MemWrite, 1'b0);
    rst = 1'b1;
    tick();

    // Fetch only
    if_req = 1'b1; if_addr = 12'h000;
    chk("f0_stall", if_stall, 1'b0);
    tick();
    chk("f0_valid", if_valid, 1'b1);
    chk("f0_instr", if_instr, 32'h00000013);
    if_addr = 12'h004;
    chk("f1_stall", if_stall, 1'b0);
    tick();
    chk("f1_valid", if_valid, 1'b1);
    chk("f1_instr", if_instr, 32'h12345678);
    chk("f1_stall_after", if_stall, 1'b0);
    if_req = 1'b0;
    tick();
    chk("f_idle_valid", if_valid, 1'b0);

    // Word load at 1000 with fetch held
    if_req = 1'b1; if_addr = 12'h008;
    drive_dm(1'b1, 1'b0, 2'b10, 1'b0, 12'd1000, '0);
    chk("wl_ready_N", dm_ready, 1'b1);
    tick();
    dm_req = 1'b0;
    #1;
    chk("wl_fetch_valid", if_valid, 1'b1);
    chk("wl_fetch_instr", if_instr, 32'h000000AA);
    chk("wl_stall_N1", if_stall, 1'b1);
    chk("wl_ready_N1", dm_ready, 1'b0);
    chk("wl_port", {MemRead, MemWrite, 20'(addr)}, {2'b10, 20'd1000});
    tick();
    chk("wl_done", dm_done, 1'b1);
    chk("wl_rdata", dm_rdata, 32'd17);
    chk("wl_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("wl_no_fetch_N1", if_valid, 1'b0);
    if_req = 1'b0;
    tick();

    // Table of data requests
    for (int i = 0; i < 10; i++) begin
      drive_dm(1'b1, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].a, vecs[i].wd);
      #1;
      if (vecs[i].err) chk($sformatf("tbl%0d_port_idle_N", i), {MemRead, MemWrite}, 2'b00);
      tick();
      dm_req = 1'b0;
      chk($sformatf("tbl%0d_err", i), dm_err, vecs[i].err);
      if (vecs[i].err) chk($sformatf("tbl%0d_port_idle_N1", i), {MemRead, MemWrite}, 2'b00);
      else chk($sformatf("tbl%0d_memwrite", i), MemWrite, vecs[i].we);
      tick();
      chk($sformatf("tbl%0d_done", i), dm_done, !vecs[i].err);
      chk($sformatf("tbl%0d_rdata", i), dm_rdata, vecs[i].rd);
    end
    chk("tbl_stall_cnt", 32'(stall_cnt), 32'd8);
    chk("tbl_mem_unchanged", {mem[3], mem[2], mem[1], mem[0]}, 32'h00000013);
    chk("tbl_mem_unchanged2", {mem[7], mem[6], mem[5], mem[4]}, 32'h12345678);

    // Continuous dm_req: alternating fetch/data
    if_req = 1'b1; if_addr = 12'h000;
    drive_dm(1'b1, 1'b0, 2'b10, 1'b0, 12'h004, '0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("alt%0d_ready", k), dm_ready, (k % 2 == 0));
      tick();
      chk($sformatf("alt%0d_if_valid", k), if_valid, (k % 2 == 0));
      chk($sformatf("alt%0d_done", k), dm_done, (k % 2 == 1));
    end
    chk("alt_rdata", dm_rdata, 32'h12345678);
    chk("alt_stall_cnt", 32'(stall_cnt), 32'd10);
    if_req = 1'b0; dm_req = 1'b0;
    tick();

    // Reset during an in-flight store
    drive_dm(1'b1, 1'b1, 2'b10, 1'b0, 12'd1004, 32'hDEADBEEF);
    tick();
    dm_req = 1'b0;
    #1;
    chk("rs_store_presented", MemWrite, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("rs_memwrite", MemWrite, 1'b0);
    chk("rs_ready_stall", {dm_ready, if_stall}, 2'b10);
    chk("rs_stall_cnt", 32'(stall_cnt), 32'h0);
    chk("rs_regs", {if_instr, dm_rdata}, 64'h0);
    chk("rs_pulses", {if_valid, dm_done, dm_err}, 3'b000);
    tick();
    chk("rs_mem1004", {mem[1007], mem[1006], mem[1005], mem[1004]}, 32'd9);
    #2 rst = 1'b1;
    tick();
    chk("rs_release_ready", dm_ready, 1'b1);

    // Randomized run against the reference model
    for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
    m_pend = 1'b0; m_rdata = '0; m_instr = '0; m_stall = '0;
    p_we = 1'b0; p_sz = 2'd0; p_uns = 1'b0; p_a = '0; p_wd = '0;
    for (int c = 0; c < 600; c++) begin
      int r;
      if_req  = 1'($urandom_range(0, 1));
      if_addr = 12'($urandom_range(0, 1023) * 4);
      r = int'($urandom_range(0, 9));
      drive_dm(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
               1'($urandom_range(0, 1)), 12'h3C0 + 12'($urandom_range(0, 63)), $urandom);
      model_step();
      tick();
      chk("rnd_if_valid", if_valid, e_valid);
      chk("rnd_if_instr", if_instr, m_instr);
      chk("rnd_dm_done", dm_done, e_done);
      chk("rnd_dm_err", dm_err, e_err);
      chk("rnd_dm_rdata", dm_rdata, m_rdata);
      chk("rnd_stall_cnt", 32'(stall_cnt), 32'(m_stall));
      chk("rnd_ready_stall", {dm_ready, if_stall}, {!m_pend, m_pend});
    end
    begin
      int diffs = 0;
      for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk("rnd_mem_image_diffs", 32'(diffs), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
